// File: rtl/register_arbiter.sv
// Round-robin arbiter that lets N requesters take turns loading one shared WIDTH-bit register.
// Latency: grant 1 edge after req is sampled in IDLE, q/ack 1 edge later, back to IDLE 1 edge after that.
// Backpressure: losers and late requesters keep req high and are served in a later IDLE; none are dropped.
//
// Ports:
//   clk, reset     rising-edge clock, asynchronous active-low reset
//   req[N]         per-requester request, held until its ack (or dropped to abandon)
//   d_bus[N*WIDTH] requester i data at bits [i*WIDTH +: WIDTH]
//   grant[N]       registered one-hot grant, high through IDLE->LOAD->ACK
//   ack[N]         one-cycle one-hot pulse, coincides with the new value on q
//   q[WIDTH]       shared register
//   owner          index of the current or most recent grantee
//   busy           high whenever the FSM is not in IDLE
//   wr_count[8]    completed-write counter, wraps 255->0
module register_arbiter #(
    parameter int WIDTH = 7,
    parameter int N     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic [N*WIDTH-1:0]   d_bus,
    output logic [N-1:0]         grant,
    output logic [N-1:0]         ack,
    output logic [WIDTH-1:0]     q,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic [7:0]           wr_count
);

    localparam int IW = $clog2(N);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    localparam logic [N-1:0] ONE_HOT0 = {{(N-1){1'b0}}, 1'b1};

    logic [1:0]       r_state;
    logic [N-1:0]     r_grant;
    logic [N-1:0]     r_ack;
    logic [WIDTH-1:0] r_q;
    logic [IW-1:0]    r_owner;
    logic [IW-1:0]    r_ptr;
    logic [7:0]       r_cnt;

    logic [WIDTH-1:0] w_d [N];
    logic [IW-1:0]    w_winner;
    logic             w_found;
    logic [IW-1:0]    w_ptr_next;

    // Slice the flat data bus into per-requester words.
    for (genvar gi = 0; gi < N; gi++) begin : g_unpack
        assign w_d[gi] = d_bus[gi*WIDTH +: WIDTH];
    end

    // Scan ptr, ptr+1, ..., wrapping at N; the first set req bit wins.
    always_comb begin
        logic [IW-1:0] idx;
        idx      = r_ptr;
        w_winner = '0;
        w_found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && req[idx]) begin
                w_winner = idx;
                w_found  = 1'b1;
            end
            idx = (idx == IW'(N-1)) ? '0 : idx + 1'b1;
        end
    end

    // The pointer moves just past the requester that completed a write.
    assign w_ptr_next = (r_owner == IW'(N-1)) ? '0 : r_owner + 1'b1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_ack   <= '0;
            r_q     <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= ONE_HOT0 << w_winner;
                        r_owner <= w_winner;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (req[r_owner]) begin
                        r_q     <= w_d[r_owner];
                        r_ack   <= r_grant;
                        r_cnt   <= r_cnt + 8'd1;
                        r_state <= S_ACK;
                    end else begin
                        // Requester gave up: no write, pointer stays so the
                        // next scan starts from the same place.
                        r_grant <= '0;
                        r_state <= S_IDLE;
                    end
                end
                S_ACK: begin
                    r_grant <= '0;
                    r_ack   <= '0;
                    r_ptr   <= w_ptr_next;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_grant <= '0;
                    r_ack   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign grant    = r_grant;
    assign ack      = r_ack;
    assign q        = r_q;
    assign owner    = r_owner;
    assign busy     = (r_state != S_IDLE);
    assign wr_count = r_cnt;

endmodule

// File: tb/tb_register_arbiter.sv
// Directed bench for register_arbiter: stimulus pushes expected writes, a monitor checks each ack.
// Latency: each expected entry carries the absolute cycle its ack must appear in.
// Backpressure: n/a (bench drives req directly).
module tb_register_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic [27:0] d_bus;
    logic [3:0] grant;
    logic [3:0] ack;
    logic [6:0] q;
    logic [1:0] owner;
    logic       busy;
    logic [7:0] wr_count;

    logic [6:0] dv [4];
    assign d_bus = {dv[3], dv[2], dv[1], dv[0]};

    register_arbiter #(.WIDTH(7), .N(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .d_bus    (d_bus),
        .grant    (grant),
        .ack      (ack),
        .q        (q),
        .owner    (owner),
        .busy     (busy),
        .wr_count (wr_count)
    );

    typedef struct {
        logic [3:0] ack;
        logic [6:0] q;
        logic [7:0] cnt;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic setd(input int i, input logic [6:0] v);
        dv[2'(i)] = v;
    endtask

    task automatic expect_wr(input int i, input logic [6:0] v, input logic [7:0] cnt, input int c);
        exp_t x;
        x.ack = 4'b0001 << i;
        x.q   = v;
        x.cnt = cnt;
        x.cyc = c;
        sb.push_back(x);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Grant requester i, then drop its req before the LOAD edge.
    task automatic abandon(input int i, input logic [6:0] q_hold, input logic [7:0] cnt_hold);
        req = 4'b0001 << i;
        setd(i, 7'h55);
        @(negedge clk);
        check("abandon_grant", 32'(grant), 32'(4'b0001 << i));
        check("abandon_busy",  32'(busy), 32'd1);
        req = 4'b0000;
        @(negedge clk);
        check("abandon_grant_clr", 32'(grant), 32'd0);
        check("abandon_busy_clr",  32'(busy), 32'd0);
        check("abandon_q_hold",    32'(q), 32'(q_hold));
        check("abandon_cnt_hold",  32'(wr_count), 32'(cnt_hold));
    endtask

    // Monitor: every ack must match the oldest expected write.
    initial begin
        forever begin
            @(negedge clk);
            if (ack !== 4'b0000) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_ack: got ack=%b q=%h, expected no ack (cycle %0d)", ack, q, cyc);
                end else begin
                    e = sb.pop_front();
                    check("ack_vec",   32'(ack), 32'(e.ack));
                    check("ack_q",     32'(q), 32'(e.q));
                    check("ack_count", 32'(wr_count), 32'(e.cnt));
                    check("ack_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        int c0;
        reset = 1'b1;
        req   = 4'b0000;
        for (int i = 0; i < 4; i++) dv[i] = 7'h00;
        #2 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_q",     32'(q), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ack",   32'(ack), 32'd0);
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_count", 32'(wr_count), 32'd0);
        check("rst_owner", 32'(owner), 32'd0);
        reset = 1'b1;

        // Single write by requester 2; data is taken at the LOAD edge only
        @(negedge clk);
        c0  = cyc;
        req = 4'b0100;
        setd(2, 7'h11);
        expect_wr(2, 7'h2A, 8'd1, c0 + 2);
        @(negedge clk);
        check("t1_grant", 32'(grant), 32'b0100);
        check("t1_owner", 32'(owner), 32'd2);
        check("t1_busy",  32'(busy), 32'd1);
        check("t1_q_old", 32'(q), 32'd0);
        setd(2, 7'h2A);
        @(negedge clk);
        req = 4'b0000;
        setd(2, 7'h7F);
        @(negedge clk);
        check("t1_grant_clr", 32'(grant), 32'd0);
        check("t1_busy_clr",  32'(busy), 32'd0);
        check("t1_q_hold",    32'(q), 32'h2A);

        // All four held: order 0,1,2,3,0, three cycles apart
        do_reset();
        c0  = cyc;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) setd(i, 7'(16 + i));
        for (int j = 0; j < 5; j++) expect_wr(j % 4, 7'(16 + j % 4), 8'(j + 1), c0 + 2 + 3 * j);
        repeat (14) @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        check("t2_count", 32'(wr_count), 32'd5);

        // ptr=1 -> 1 wins; ptr=2 -> 0 beats 1; ptr=1 -> 1 again
        c0  = cyc;
        req = 4'b0011;
        setd(0, 7'h20);
        setd(1, 7'h21);
        expect_wr(1, 7'h21, 8'd6, c0 + 2);
        expect_wr(0, 7'h20, 8'd7, c0 + 5);
        expect_wr(1, 7'h21, 8'd8, c0 + 8);
        repeat (8) @(negedge clk);
        req = 4'b0000;
        @(negedge clk);

        // Abandoned grants leave ptr at 2: next scan from 2 picks 3, then 0, then 1
        abandon(1, 7'h21, 8'd8);
        abandon(3, 7'h21, 8'd8);
        c0  = cyc;
        req = 4'b1011;
        setd(0, 7'h30);
        setd(1, 7'h31);
        setd(3, 7'h33);
        expect_wr(3, 7'h33, 8'd9,  c0 + 2);
        expect_wr(0, 7'h30, 8'd10, c0 + 5);
        expect_wr(1, 7'h31, 8'd11, c0 + 8);
        repeat (8) @(negedge clk);
        req = 4'b0000;
        @(negedge clk);

        // Reset in the middle of LOAD clears everything at once
        req = 4'b0001;
        setd(0, 7'h44);
        @(negedge clk);
        check("t5_grant_pre", 32'(grant), 32'b0001);
        reset = 1'b0;
        #1;
        check("t5_q",     32'(q), 32'd0);
        check("t5_grant", 32'(grant), 32'd0);
        check("t5_ack",   32'(ack), 32'd0);
        check("t5_busy",  32'(busy), 32'd0);
        check("t5_count", 32'(wr_count), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        c0 = cyc;
        expect_wr(0, 7'h44, 8'd1, c0 + 2);
        @(negedge clk);
        check("t5_grant_rel", 32'(grant), 32'b0001);
        @(negedge clk);
        req = 4'b0000;
        @(negedge clk);

        // Counter wrap: write 256 lands at 0, write 257 at 1
        do_reset();
        c0  = cyc;
        req = 4'b0001;
        setd(0, 7'h5A);
        for (int j = 0; j < 257; j++) expect_wr(0, 7'h5A, 8'(j + 1), c0 + 2 + 3 * j);
        repeat (3 * 257 - 1) @(negedge clk);
        req = 4'b0000;
        @(negedge clk);
        check("t6_count_wrap", 32'(wr_count), 32'd1);

        repeat (5) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/register_arbiter.md
# register_arbiter

Shares one WIDTH-bit storage register among N requesters using round-robin arbitration and a req/grant/ack handshake. It sits in front of the 7-bit register datapath and replaces direct `d` drive with a sequenced, one-writer-at-a-time load. It also reports the last writer and keeps a running write count.

## Interface
- WIDTH, 7, data width of the shared register
- N, 4, number of requesters (2..8)
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- req  input  N  request, bit i from requester i; held high until ack[i] or abandoned
- d_bus  input  N*WIDTH  requester i data at bits [i*WIDTH +: WIDTH]
- grant  output  N  one-hot grant, registered
- ack  output  N  one-hot, 1-cycle pulse: the write by requester i has landed in q
- q  output  WIDTH  shared register contents
- owner  output  clog2(N)  index of the current or most recent grantee
- busy  output  1  high whenever state != IDLE
- wr_count  output  8  number of completed writes, wraps 255->0

## Operation
- FSM states: IDLE, LOAD, ACK; encoding is free.
- IDLE:
  - If req==0, stay in IDLE.
  - Else pick the winner as the first set req bit scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - Set grant<=onehot(winner), owner<=winner, and go to LOAD.
- LOAD:
  - If req[owner]==1: set q<=d_bus[owner], ack<=onehot(owner), wr_count<=wr_count+1, and go to ACK.
  - If req[owner]==0 (abandoned): no write, no ack, grant<=0, ptr unchanged, go to IDLE.
- ACK:
  - Set grant<=0, ack<=0, ptr<=(owner+1) mod N, and go to IDLE.
- Round-robin pointer:
  - ptr is internal, clog2(N) bits, reset to 0.
  - It advances only on a completed write.
- Data sampling: d_bus[owner] is sampled only at the LOAD edge. Data changes in other cycles are ignored.
- Non-granted inputs: req and d_bus from non-granted requesters are ignored while busy. They wait and are not lost, provided req stays high.
- Repeated requests: a requester that keeps req high after its ack is re-arbitrated in the next IDLE at the lowest priority (ptr has moved past it).
- Reset (reset==0) takes effect immediately, independent of clk, in any state:
  - state=IDLE, q=0, grant=0, ack=0, owner=0, busy=0, wr_count=0, ptr=0.
  - A write in flight is discarded with no ack.

## Timing
- Example sequence, with req[i] sampled high at edge k in IDLE:
  - Edge k: grant[i]=1, busy=1.
  - Edge k+1: q=d_bus[i] value at k+1, ack[i]=1, wr_count increments.
  - Edge k+2: grant=0, ack=0, busy=0.
- Cycle counts:
  - Latency from req sample to new q: 2 cycles.
  - grant is high 2 cycles.
  - ack is high exactly 1 cycle and coincides with the first cycle q shows the new value.
- Throughput: one write per 3 cycles. Back-to-back requests re-enter LOAD 3 edges apart.
- Simultaneous requests: resolved by ptr at the IDLE edge only. Requests arriving while busy are first seen in the next IDLE cycle.
- Abandonment: req[owner] dropping exactly at the LOAD edge counts as abandoned (req is sampled at that edge).
- Reset release: the first edge with reset==1 is treated as IDLE.
- wr_count wraps from 255 to 0 with no flag.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset, then req=4'b0100, d_bus[2]=7'h2A -> grant=0100 one cycle after the sample edge; next edge q=7'h2A, ack=0100, wr_count=1; busy low after the third edge.
- req=4'b1111 held, data i=7'h10+i -> writes occur in order 0,1,2,3,0, 3 cycles apart; q=10,11,12,13,10; wr_count=5.
- ptr=2 (after a write by 1), req=4'b0011 -> requester 0 wins before 1; ptr=1 -> requester 1 wins.
- req[1] dropped in the cycle after grant[1] -> no ack, q unchanged, wr_count unchanged, next winner chosen from ptr unchanged.
- reset pulled low mid-LOAD (between edges) -> q, grant, ack, busy, wr_count go to 0 immediately; after release, a pending req=0001 gets grant on the next edge.
- 256 completed writes -> wr_count returns to 0; the 257th write makes it 1.
